car_park_gate_ctrl: RTL and testbench
=====================================

# car_park_gate_ctrl

Sequences the single-lane car park ramp: arbitrates between the entry and exit barrier requests and opens one barrier at a time. Once a car has passed, it issues a one-cycle enter or exit pulse to the occupancy counter, then holds the lane closed briefly before serving the next request. Entry is refused while the park is full and exit while it is empty, using the counter's 4-bit car_count fed back as an input.

## Interface
- CAPACITY, 15: maximum occupancy. Entry is refused when car_count >= CAPACITY. Legal range 1..15.
- OPEN_TIMEOUT, 1000: clock cycles a barrier stays open waiting for the pass beam before it aborts. Must be ≥ 2.
- CLOSE_HOLD, 4: cycles the lane stays blocked after a barrier closes. Must be ≥ 1.

- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- entry_req  input  1  a car is waiting at the entry loop (level).
- exit_req  input  1  a car is waiting at the exit loop (level).
- entry_pass  input  1  the entry pass beam is broken (car through the barrier).
- exit_pass  input  1  the exit pass beam is broken.
- car_count  input  4  current occupancy from the counter.
- entry_open  output  1  entry barrier raise command.
- exit_open  output  1  exit barrier raise command.
- enter  output  1  one-cycle increment pulse to the counter.
- exit  output  1  one-cycle decrement pulse to the counter.
- full  output  1  registered flag: car_count >= CAPACITY.
- abort  output  1  one-cycle pulse when an open barrier times out.

## Operation
- States:
  - IDLE
  - ENTRY_OPEN
  - EXIT_OPEN
  - HOLD
- All outputs are registered. Reset value of every output is 0.
- Reset forces IDLE, clears the timer, and sets last_served = EXIT so that entry wins the first tie.
- Eligibility:
  - Entry is eligible when entry_req=1 and car_count < CAPACITY.
  - Exit is eligible when exit_req=1 and car_count != 0.
- IDLE:
  - If only one side is eligible, go to that side's OPEN state.
  - If both are eligible, round-robin: serve the side opposite last_served, then update last_served.
  - If neither is eligible, stay in IDLE.
- ENTRY_OPEN / EXIT_OPEN:
  - The matching *_open output is 1 throughout the state.
  - The timer counts from 0 on state entry.
  - If the matching pass input is 1: go to HOLD, pulse enter (or exit) for exactly one cycle, and drop *_open.
  - Else, if the timer reaches OPEN_TIMEOUT-1: go to HOLD, pulse abort, and produce no counter pulse.
  - The pass input of the opposite side is ignored.
  - The req inputs are ignored once the barrier is open.
- HOLD:
  - Both barriers are closed.
  - Stay CLOSE_HOLD cycles, then go to IDLE.
  - A request still held on return to IDLE is re-arbitrated as a new car.
- full tracks car_count every cycle with one cycle of latency, independent of state.
- Timer width is clog2(OPEN_TIMEOUT+1) bits. It saturates and never wraps.
- Reset mid-operation: barriers drop and no enter, exit or abort pulse is generated.

## Timing
- Request to barrier open: a request sampled at edge N gives *_open = 1 from edge N+1.
- Pass to pulse: a pass input sampled at edge M gives enter/exit = 1 for cycle M+1 only, with *_open = 0 from edge M+1.
- Pass and timeout on the same edge: pass wins, so a counter pulse is generated and abort is not.
- Minimum service time per car: 1 (open) + 1 (pass) + CLOSE_HOLD cycles back to IDLE.
- Never both barriers open, and never both enter and exit asserted, in the same cycle.

## Structure
- Package car_park_pkg holds:
  - the state enum (IDLE, ENTRY_OPEN, EXIT_OPEN, HOLD);
  - the side enum used for last_served;
  - CAR_COUNT_W = 4.
- Sub-module gate_timer: a loadable up-counter with clear and a terminal-count output. It serves both the OPEN_TIMEOUT and the CLOSE_HOLD counts.

## Test plan
- Single entry, count=3: raise entry_req. Expect entry_open next cycle. Assert entry_pass. Expect enter=1 for one cycle, entry_open=0, then IDLE after 4 HOLD cycles.
- Full lot, count=15: hold entry_req for 50 cycles. Expect entry_open=0, enter=0 and full=1 throughout. Then assert exit_req. Expect the exit to be served.
- Simultaneous requests, count=5: after reset, hold both req continuously. Expect service order entry, exit, entry, exit, each completed by a pass pulse.
- Timeout with OPEN_TIMEOUT=8: open the entry barrier and never assert pass. Expect abort=1 at the 8th open cycle, no enter pulse, then HOLD.
- Empty lot, count=0: hold exit_req. Expect no exit_open. Then raise entry_req and expect the entry to be served.
- Reset mid-open, count=5: assert rst while exit_open=1. Expect all outputs 0 immediately. After release, expect IDLE with entry priority.

Source files
------------

// File: rtl/car_park_pkg.sv
// -----------------------------------------------------------------------------
// car_park_pkg
// Shared definitions for the single-lane car park ramp sequencer.
//   CAR_COUNT_W  width of the occupancy count fed back from the counter
//   IDLE .. HOLD sequencer state encodings
//   side_t       which barrier was served most recently (round-robin memory)
// -----------------------------------------------------------------------------
package car_park_pkg;

   localparam int CAR_COUNT_W = 4;

   // Sequencer states, kept as plain constants so older code can share them.
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] ENTRY_OPEN = 2'd1;
   localparam logic [1:0] EXIT_OPEN  = 2'd2;
   localparam logic [1:0] HOLD       = 2'd3;

   typedef enum logic {
      SIDE_ENTRY = 1'b0,
      SIDE_EXIT  = 1'b1
   } side_t;

endpackage

// File: rtl/car_park_gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// Loadable up-counter shared by the barrier-open timeout and the close hold.
// Loading restarts the count at 0 and latches the terminal value; tc is high
// while the count equals that terminal value. The count saturates, never wraps.
//   clk, rst  clock and asynchronous active-high reset
//   clear     restart the count at 0, keep the terminal value
//   load      restart the count at 0 and latch load_val as the terminal value
//   load_val  terminal value for the next run
//   en        advance the count by one
//   tc        count has reached the terminal value
// -----------------------------------------------------------------------------
module gate_timer
   import car_park_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count;
   logic [W-1:0] limit;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         limit <= '0;
      end else if (load) begin
         count <= '0;
         limit <= load_val;
      end else if (clear) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == limit);

endmodule

// File: rtl/car_park_gate_ctrl.sv
// -----------------------------------------------------------------------------
// car_park_gate_ctrl
// Sequences a single-lane car park ramp: arbitrates between the entry and exit
// requests, opens one barrier at a time, pulses the occupancy counter once the
// car has passed, then holds the lane closed for CLOSE_HOLD cycles.
//   clk, rst    clock and asynchronous active-high reset
//   entry_req   car waiting at the entry loop (level)
//   exit_req    car waiting at the exit loop (level)
//   entry_pass  entry pass beam broken
//   exit_pass   exit pass beam broken
//   car_count   current occupancy from the counter
//   entry_open  entry barrier raise command
//   exit_open   exit barrier raise command
//   enter       one-cycle increment pulse to the counter
//   exit        one-cycle decrement pulse to the counter
//   full        registered car_count >= CAPACITY
//   abort       one-cycle pulse when an open barrier times out
// All outputs are registered and reset to 0.
// -----------------------------------------------------------------------------
module car_park_gate_ctrl
   import car_park_pkg::*;
#(
   parameter int CAPACITY     = 15,
   parameter int OPEN_TIMEOUT = 1000,
   parameter int CLOSE_HOLD   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   entry_req,
   input  logic                   exit_req,
   input  logic                   entry_pass,
   input  logic                   exit_pass,
   input  logic [CAR_COUNT_W-1:0] car_count,
   output logic                   entry_open,
   output logic                   exit_open,
   output logic                   enter,
   output logic                   exit,
   output logic                   full,
   output logic                   abort
);

   localparam int TW = $clog2(OPEN_TIMEOUT + 1);

   // Terminal values: the timer reads 0 in the first cycle of a state, so the
   // last cycle of an N-cycle window is N-1. CLOSE_HOLD must fit in TW bits.
   localparam logic [TW-1:0]          OPEN_LAST = TW'(OPEN_TIMEOUT - 1);
   localparam logic [TW-1:0]          HOLD_LAST = TW'(CLOSE_HOLD - 1);
   localparam logic [CAR_COUNT_W-1:0] CAP       = CAR_COUNT_W'(CAPACITY);

   logic [1:0] state, state_d;
   side_t      last_served, last_served_d;

   logic entry_open_d, exit_open_d, enter_d, exit_d, abort_d;
   logic entry_ok, exit_ok, pick_entry, pick_exit;

   logic          t_clear, t_load, t_en, t_tc;
   logic [TW-1:0] t_load_val;

   gate_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (t_clear),
      .load     (t_load),
      .load_val (t_load_val),
      .en       (t_en),
      .tc       (t_tc)
   );

   // Eligibility and round-robin pick: on a tie, serve the side that was not
   // served last.
   assign entry_ok   = entry_req && (car_count < CAP);
   assign exit_ok    = exit_req && (car_count != '0);
   assign pick_entry = entry_ok && (!exit_ok || (last_served == SIDE_EXIT));
   assign pick_exit  = exit_ok && !pick_entry;

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state;
      last_served_d = last_served;
      entry_open_d  = 1'b0;
      exit_open_d   = 1'b0;
      enter_d       = 1'b0;
      exit_d        = 1'b0;
      abort_d       = 1'b0;
      t_clear       = 1'b0;
      t_load        = 1'b0;
      t_load_val    = OPEN_LAST;
      t_en          = 1'b0;

      case (state)
         IDLE: begin
            t_clear = 1'b1;
            if (pick_entry) begin
               state_d       = ENTRY_OPEN;
               last_served_d = SIDE_ENTRY;
               entry_open_d  = 1'b1;
               t_load        = 1'b1;
            end else if (pick_exit) begin
               state_d       = EXIT_OPEN;
               last_served_d = SIDE_EXIT;
               exit_open_d   = 1'b1;
               t_load        = 1'b1;
            end
         end

         // Pass is tested before the timeout so a car that clears the beam on
         // the final cycle is still counted.
         ENTRY_OPEN: begin
            t_en = 1'b1;
            if (entry_pass) begin
               state_d    = HOLD;
               enter_d    = 1'b1;
               t_load     = 1'b1;
               t_load_val = HOLD_LAST;
            end else if (t_tc) begin
               state_d    = HOLD;
               abort_d    = 1'b1;
               t_load     = 1'b1;
               t_load_val = HOLD_LAST;
            end else begin
               entry_open_d = 1'b1;
            end
         end

         EXIT_OPEN: begin
            t_en = 1'b1;
            if (exit_pass) begin
               state_d    = HOLD;
               exit_d     = 1'b1;
               t_load     = 1'b1;
               t_load_val = HOLD_LAST;
            end else if (t_tc) begin
               state_d    = HOLD;
               abort_d    = 1'b1;
               t_load     = 1'b1;
               t_load_val = HOLD_LAST;
            end else begin
               exit_open_d = 1'b1;
            end
         end

         HOLD: begin
            t_en = 1'b1;
            if (t_tc) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // last_served resets to EXIT so entry wins the first tie after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= SIDE_EXIT;
         entry_open  <= 1'b0;
         exit_open   <= 1'b0;
         enter       <= 1'b0;
         exit        <= 1'b0;
         abort       <= 1'b0;
         full        <= 1'b0;
      end else begin
         state       <= state_d;
         last_served <= last_served_d;
         entry_open  <= entry_open_d;
         exit_open   <= exit_open_d;
         enter       <= enter_d;
         exit        <= exit_d;
         abort       <= abort_d;
         full        <= (car_count >= CAP);
      end
   end

endmodule

// File: tb/tb_car_park_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_park_gate_ctrl
// Directed bench for car_park_gate_ctrl with CAPACITY=15, OPEN_TIMEOUT=8,
// CLOSE_HOLD=4. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so each tick() shows the result of one edge.
// -----------------------------------------------------------------------------
module tb_car_park_gate_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       entry_pass = 1'b0;
   logic       exit_pass = 1'b0;
   logic [3:0] car_count = 4'd0;
   logic       entry_open, exit_open, enter, exit, full, abort;
   logic [5:0] outs;

   int checks = 0;
   int errors = 0;

   assign outs = {entry_open, exit_open, enter, exit, full, abort};

   car_park_gate_ctrl #(
      .CAPACITY     (15),
      .OPEN_TIMEOUT (8),
      .CLOSE_HOLD   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .entry_req  (entry_req),
      .exit_req   (exit_req),
      .entry_pass (entry_pass),
      .exit_pass  (exit_pass),
      .car_count  (car_count),
      .entry_open (entry_open),
      .exit_open  (exit_open),
      .enter      (enter),
      .exit       (exit),
      .full       (full),
      .abort      (abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic settle();
      entry_req  = 1'b0;
      exit_req   = 1'b0;
      entry_pass = 1'b0;
      exit_pass  = 1'b0;
      repeat (8) tick();
   endtask

   // Ticks until a barrier opens, bounded; n is the number of edges taken.
   task automatic wait_open(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(entry_open || exit_open) && (n < 30));
   endtask

   initial begin
      int n;
      int bad;

      // ---- reset state and single entry, count=3 ----------------------------
      car_count = 4'd3;
      do_reset();
      check("reset_outs", 32'(outs), 32'h0);

      entry_req = 1'b1;
      tick();
      check("t1_entry_open", 32'(entry_open), 32'd1);
      check("t1_exit_closed", 32'(exit_open), 32'd0);
      check("t1_full_low", 32'(full), 32'd0);

      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      check("t1_enter_pulse", 32'({entry_open, enter, exit, abort}), 32'b0100);
      tick();
      check("t1_enter_once", 32'(enter), 32'd0);
      tick();
      tick();
      check("t1_hold_closed", 32'(entry_open), 32'd0);
      tick();
      check("t1_idle_closed", 32'(entry_open), 32'd0);
      tick();
      check("t1_rearbitrate", 32'(entry_open), 32'd1);
      entry_req  = 1'b0;
      entry_pass = 1'b1;
      tick();
      check("t1_enter_again", 32'(enter), 32'd1);
      settle();

      // ---- full lot, count=15 ------------------------------------------------
      car_count = 4'd15;
      check("t2_full_latency", 32'(full), 32'd0);
      entry_req = 1'b1;
      tick();
      check("t2_full_set", 32'(full), 32'd1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (entry_open || enter || !full) bad++;
      end
      check("t2_entry_refused", 32'(bad), 32'd0);
      exit_req = 1'b1;
      tick();
      check("t2_exit_open", 32'({entry_open, exit_open}), 32'b01);
      exit_req  = 1'b0;
      exit_pass = 1'b1;
      tick();
      exit_pass = 1'b0;
      check("t2_exit_pulse", 32'({exit_open, enter, exit, abort}), 32'b0010);
      settle();

      // ---- simultaneous requests, count=5: entry, exit, entry, exit ----------
      car_count = 4'd5;
      do_reset();
      entry_req = 1'b1;
      exit_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_open(n);
         check("t3_latency", 32'(n), (i == 0) ? 32'd1 : 32'd5);
         check("t3_side", 32'({entry_open, exit_open}), (i % 2 == 0) ? 32'b10 : 32'b01);
         if (i == 0) begin
            // The opposite pass beam must not close the entry barrier.
            exit_pass = 1'b1;
            tick();
            exit_pass = 1'b0;
            check("t3_other_pass_ignored", 32'({entry_open, exit, enter}), 32'b100);
         end
         if (i % 2 == 0) entry_pass = 1'b1;
         else            exit_pass  = 1'b1;
         tick();
         entry_pass = 1'b0;
         exit_pass  = 1'b0;
         check("t3_pulse", 32'({enter, exit}), (i % 2 == 0) ? 32'b10 : 32'b01);
      end
      settle();

      // ---- timeout: barrier open for 8 cycles, then abort --------------------
      car_count = 4'd3;
      do_reset();
      entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         if (!entry_open || abort || enter) bad++;
         tick();
      end
      if (!entry_open || abort) bad++;
      check("t4_open_window", 32'(bad), 32'd0);
      tick();
      check("t4_abort", 32'({entry_open, enter, abort}), 32'b001);
      tick();
      check("t4_abort_once", 32'({entry_open, abort}), 32'b00);
      settle();

      // ---- pass on the timeout cycle: pass wins ------------------------------
      entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      repeat (7) tick();
      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      check("t4_pass_wins", 32'({enter, abort}), 32'b10);
      settle();

      // ---- empty lot, count=0 -----------------------------------------------
      car_count = 4'd0;
      exit_req  = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (exit_open || exit) bad++;
      end
      check("t5_exit_refused", 32'(bad), 32'd0);
      entry_req = 1'b1;
      tick();
      check("t5_entry_open", 32'({entry_open, exit_open}), 32'b10);
      entry_req  = 1'b0;
      entry_pass = 1'b1;
      tick();
      check("t5_enter", 32'(enter), 32'd1);
      settle();

      // ---- reset while the exit barrier is open, count=5 ---------------------
      car_count = 4'd5;
      exit_req  = 1'b1;
      tick();
      check("t6_exit_open", 32'(exit_open), 32'd1);
      exit_pass = 1'b1;
      rst       = 1'b1;
      #1;
      check("t6_async_clear", 32'(outs), 32'h0);
      tick();
      check("t6_no_pulse", 32'(outs), 32'h0);
      exit_pass = 1'b0;
      entry_req = 1'b1;
      rst       = 1'b0;
      tick();
      check("t6_entry_priority", 32'({entry_open, exit_open}), 32'b10);
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
